bit_packer: RTL and testbench

Serialises the variable-length bitstream fields produced by the frame-header and slice-encoding stages (tokens of `val`, `size_of_bit`, `output_enable`, `flush_bit`) into left-justified, MSB-first 64-bit words for the output byte stream. It sits directly downstream of the header/slice field generators and upstream of the output memory/DMA writer. The block zero-pads to a byte boundary on flush, reports valid bytes per emitted word and keeps a running byte count.

---
 rtl/bit_packer.sv | 111 +++++++++++
 tb/tb_bit_packer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// bit_packer: packs variable-length MSB-first fields into left-justified 64-bit words
module bit_packer #(
  parameter int WORD_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              input_enable,
  input  logic [WORD_W-1:0] val,
  input  logic [63:0]       size_of_bit,
  input  logic              flush_bit,
  output logic              output_enable,
  output logic [WORD_W-1:0] output_data,
  output logic [3:0]        output_byte_count,
  output logic [31:0]       total_bytes,
  output logic              size_error,
  output logic              protocol_error
);
  typedef enum logic {RUN, TAIL} state_t;
  state_t             state_q, state_d;
  logic [127:0]       acc_q, acc_d, acc_a, app;
  logic [6:0]         fill_q, fill_d;
  logic [63:0]        tail_q, tail_d, od_q, od_d, mask;
  logic [3:0]         tcnt_q, tcnt_d, cnt_q, cnt_d;
  logic [31:0]        total_q, total_d;
  logic               oe_q, oe_d, serr_q, serr_d, perr_q, perr_d;
  logic               size_big, take, flush;
  logic [7:0]         s8, fill_a, rnd, rnd_tail, fill_sub;
  // Append the incoming field, then decide between word emission, flush or tail
  always_comb begin
    size_big = size_of_bit > 64'd64;
    take     = input_enable && state_q == RUN && !size_big && size_of_bit[6:0] != 7'd0;
    flush    = input_enable && state_q == RUN && flush_bit;
    s8       = take ? {1'b0, size_of_bit[6:0]} : 8'd0;
    mask     = (s8 == 8'd64) ? '1 : ((64'd1 << s8[5:0]) - 64'd1);
    app      = take ? ({64'd0, val & mask} << (8'd128 - s8 - {1'b0, fill_q})) : '0;
    acc_a    = acc_q | app;
    fill_a   = {1'b0, fill_q} + s8;
    rnd      = (fill_a + 8'd7) & 8'hF8;
    rnd_tail = rnd - 8'd64;
    fill_sub = fill_a - 8'd64;
    state_d  = RUN;
    acc_d    = acc_a;
    fill_d   = fill_a[6:0];
    oe_d     = 1'b0;
    od_d     = '0;
    cnt_d    = '0;
    tail_d   = tail_q;
    tcnt_d   = tcnt_q;
    total_d  = total_q + (oe_q ? {28'd0, cnt_q} : 32'd0);
    serr_d   = serr_q | (input_enable && state_q == RUN && size_big);
    perr_d   = perr_q | (input_enable && state_q == TAIL);
    if (state_q == TAIL) begin
      oe_d  = 1'b1;
      od_d  = tail_q;
      cnt_d = tcnt_q;
    end else if (flush) begin
      acc_d  = '0;
      fill_d = '0;
      if (rnd != 8'd0) begin
        oe_d  = 1'b1;
        od_d  = acc_a[127:64];
        cnt_d = (rnd > 8'd64) ? 4'd8 : rnd[6:3];
      end
      if (rnd > 8'd64) begin
        state_d = TAIL;
        tail_d  = acc_a[63:0];
        tcnt_d  = rnd_tail[6:3];
      end
    end else if (fill_a >= 8'd64) begin
      oe_d   = 1'b1;
      od_d   = acc_a[127:64];
      cnt_d  = 4'd8;
      acc_d  = acc_a << 64;
      fill_d = fill_sub[6:0];
    end
  end
  // State and registered outputs; reset discards partial bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      tcnt_q  <= '0;
      oe_q    <= 1'b0;
      od_q    <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      serr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      tcnt_q  <= tcnt_d;
      oe_q    <= oe_d;
      od_q    <= od_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      serr_q  <= serr_d;
      perr_q  <= perr_d;
    end
  end
  assign output_enable     = oe_q;
  assign output_data       = od_q;
  assign output_byte_count = cnt_q;
  assign total_bytes       = total_q;
  assign size_error        = serr_q;
  assign protocol_error    = perr_q;
endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: scoreboard bench for bit_packer with directed vectors
module tb_bit_packer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        input_enable = 1'b0;
  logic [63:0] val = '0;
  logic [63:0] size_of_bit = '0;
  logic        flush_bit = 1'b0;
  logic        output_enable;
  logic [63:0] output_data;
  logic [3:0]  output_byte_count;
  logic [31:0] total_bytes;
  logic        size_error;
  logic        protocol_error;
  int          checks = 0;
  int          errors = 0;
  logic [67:0] exp_q[$];

  bit_packer dut (
    .clock(clock), .reset(reset), .input_enable(input_enable), .val(val),
    .size_of_bit(size_of_bit), .flush_bit(flush_bit), .output_enable(output_enable),
    .output_data(output_data), .output_byte_count(output_byte_count),
    .total_bytes(total_bytes), .size_error(size_error), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] v, input logic [63:0] s, input logic f);
    @(negedge clock);
    input_enable = 1'b1;
    val = v;
    size_of_bit = s;
    flush_bit = f;
  endtask

  task automatic idle();
    @(negedge clock);
    input_enable = 1'b0;
    val = '0;
    size_of_bit = '0;
    flush_bit = 1'b0;
  endtask

  task automatic expect_word(input logic [63:0] d, input logic [3:0] c);
    exp_q.push_back({c, d});
  endtask

  task automatic monitor();
    logic [67:0] e;
    forever begin
      @(negedge clock);
      if (output_enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h cnt %0d expected no output", output_data, output_byte_count);
        end else begin
          e = exp_q.pop_front();
          if ({output_byte_count, output_data} !== e) begin
            errors++;
            $display("FAIL word: got %h cnt %0d expected %h cnt %0d", output_data, output_byte_count, e[63:0], e[67:64]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    @(negedge clock);
    chk("reset_oe", {63'd0, output_enable}, 64'd0);
    chk("reset_data", output_data, 64'd0);
    chk("reset_total", {32'd0, total_bytes}, 64'd0);
    reset = 1'b0;
    // header prefix
    drive(64'h4ca, 32, 1'b0);
    drive(64'h69637066, 32, 1'b0);
    expect_word(64'h000004CA_69637066, 4'd8);
    idle();
    @(negedge clock);
    chk("header_total", {32'd0, total_bytes}, 64'd8);
    // short flush
    drive(64'h0094, 16, 1'b1);
    expect_word(64'h0094_0000_0000_0000, 4'd2);
    idle();
    @(negedge clock);
    chk("short_oe_low", {63'd0, output_enable}, 64'd0);
    chk("short_total", {32'd0, total_bytes}, 64'd10);
    // sub-byte flush with masking
    drive(64'hFF, 3, 1'b0);
    drive(64'h0, 0, 1'b1);
    expect_word(64'hE000_0000_0000_0000, 4'd1);
    idle();
    @(negedge clock);
    chk("perr_before", {63'd0, protocol_error}, 64'd0);
    // straddle with tail, plus a field during the tail cycle
    drive(64'h0FFF_FFFF_FFFF_FFFF, 60, 1'b0);
    drive(64'h5A, 8, 1'b1);
    expect_word(64'hFFFF_FFFF_FFFF_FFF5, 4'd8);
    expect_word(64'hA000_0000_0000_0000, 4'd1);
    drive(64'h1234, 16, 1'b0);
    idle();
    chk("perr_set", {63'd0, protocol_error}, 64'd1);
    drive(64'h0, 0, 1'b1);
    idle();
    repeat (2) @(negedge clock);
    chk("straddle_total", {32'd0, total_bytes}, 64'd20);
    // oversize field
    chk("serr_before", {63'd0, size_error}, 64'd0);
    drive(64'hFFFF, 65, 1'b0);
    idle();
    chk("serr_set", {63'd0, size_error}, 64'd1);
    drive(64'h0, 0, 1'b1);
    idle();
    repeat (2) @(negedge clock);
    // async reset mid-packing
    drive(64'hAB_CDEF_0123, 40, 1'b0);
    idle();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_total", {32'd0, total_bytes}, 64'd0);
    chk("rst_serr", {63'd0, size_error}, 64'd0);
    chk("rst_perr", {63'd0, protocol_error}, 64'd0);
    chk("rst_oe", {63'd0, output_enable}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(64'hDEADBEEF_01234567, 64, 1'b0);
    expect_word(64'hDEADBEEF_01234567, 4'd8);
    drive(64'h0, 0, 1'b1);
    idle();
    @(negedge clock);
    chk("post_rst_total", {32'd0, total_bytes}, 64'd8);
    // total_bytes wrap
    @(negedge clock);
    force dut.total_q = 32'hFFFF_FFFC;
    #1 release dut.total_q;
    drive(64'h0123_4567_89AB_CDEF, 64, 1'b0);
    expect_word(64'h0123_4567_89AB_CDEF, 4'd8);
    idle();
    @(negedge clock);
    chk("wrap_total", {32'd0, total_bytes}, 64'd4);
    repeat (3) @(negedge clock);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
